// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC computation: sequential, PC-relative branch, or region jump.
module pc_next_logic (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        dobranch,
    input  logic        dojump,
    output logic [31:0] pcplus4,
    output logic [31:0] pc_next
);

    logic [31:0] branch_offset;
    logic        unused_opcode;

    assign pcplus4       = pc + 32'd4;
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    // Opcode bits are decoded elsewhere; only the immediate fields matter here.
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        pc_next = pcplus4;
        if (dojump) begin
            pc_next = {pcplus4[31:28], instr[25:0], 2'b00};
        end else if (dobranch) begin
            pc_next = pcplus4 + branch_offset;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, handshakes with instruction memory, holds the commit cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        dobranch,
    input  logic        dojump,
    input  logic        hold
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_next;

    pc_next_logic u_pc_next (
        .pc       (pc_q),
        .instr    (instr_q),
        .dobranch (dobranch),
        .dojump   (dojump),
        .pcplus4  (pcplus4),
        .pc_next  (pc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Branch/jump inputs only reach pc_d in EXEC, so X elsewhere cannot leak into the PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!hold) begin
                    pc_d    = pc_next;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances with different reset PCs share all inputs.
module tb_fetch_unit;

    localparam logic [31:0] RPC_A = 32'h0000_0000;
    localparam logic [31:0] RPC_B = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dobranch, dojump, hold;

    logic        req_a, req_b, val_a, val_b;
    logic [31:0] addr_a, addr_b, instr_a, instr_b, pc_a, pc_b, p4_a, p4_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC_A)) dut_a (
        .clk(clk), .reset(reset), .imem_req(req_a), .imem_addr(addr_a),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr_a),
        .instr_valid(val_a), .pc(pc_a), .pcplus4(p4_a),
        .dobranch(dobranch), .dojump(dojump), .hold(hold)
    );

    fetch_unit #(.RESET_PC(RPC_B)) dut_b (
        .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr_b),
        .instr_valid(val_b), .pc(pc_b), .pcplus4(p4_b),
        .dobranch(dobranch), .dojump(dojump), .hold(hold)
    );

    // Reference model: which step of the instruction life cycle we are in, plus PC/instr.
    int          m_step;   // 0 = after reset, 1 = waiting for memory, 2 = committing
    logic [31:0] m_pc_a, m_pc_b, m_instr;

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic br, input logic jp);
        logic [31:0]        p4;
        logic signed [15:0] imm;
        int                 off;
        p4  = p + 32'd4;
        imm = ins[15:0];
        off = imm;
        if (jp)      return (p4 & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
        else if (br) return p4 + 32'(off * 4);
        else         return p4;
    endfunction

    task automatic model_reset();
        m_step  = 0;
        m_pc_a  = RPC_A;
        m_pc_b  = RPC_B;
        m_instr = 32'h0;
    endtask

    task automatic model_step();
        if (m_step == 0) begin
            m_step = 1;
        end else if (m_step == 1) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_step  = 2;
            end
        end else if (!hold) begin
            m_pc_a = ref_next(m_pc_a, m_instr, dobranch, dojump);
            m_pc_b = ref_next(m_pc_b, m_instr, dobranch, dojump);
            m_step = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("req_a",   {31'b0, req_a}, {31'b0, m_step == 1});
        chk("req_b",   {31'b0, req_b}, {31'b0, m_step == 1});
        chk("valid_a", {31'b0, val_a}, {31'b0, m_step == 2});
        chk("valid_b", {31'b0, val_b}, {31'b0, m_step == 2});
        chk("addr_a",  addr_a,  m_pc_a);
        chk("addr_b",  addr_b,  m_pc_b);
        chk("pc_a",    pc_a,    m_pc_a);
        chk("p4_a",    p4_a,    m_pc_a + 32'd4);
        chk("p4_b",    p4_b,    m_pc_b + 32'd4);
        chk("instr_a", instr_a, m_instr);
        chk("instr_b", instr_b, m_instr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic drive(input logic ack, input logic [31:0] rd, input logic br,
                         input logic jp, input logic hd);
        imem_ack   = ack;
        imem_rdata = rd;
        dobranch   = br;
        dojump     = jp;
        hold       = hd;
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        br, jp, hd;
        logic        e_req, e_val;
        logic [31:0] e_addr_a, e_addr_b, e_instr;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int vcnt;
        // ack in IDLE and branch/jump in FETCH must all be ignored
        vecs[0]  = '{1, 32'h0,        0, 0, 0, 1, 0, 32'h00, 32'h4000_0000, 32'h0};
        vecs[1]  = '{1, 32'h2401_0001, 0, 0, 0, 0, 1, 32'h00, 32'h4000_0000, 32'h2401_0001};
        vecs[2]  = '{0, 32'h0,        0, 0, 0, 1, 0, 32'h04, 32'h4000_0004, 32'h2401_0001};
        vecs[3]  = '{1, 32'h2402_0002, 0, 0, 0, 0, 1, 32'h04, 32'h4000_0004, 32'h2402_0002};
        vecs[4]  = '{0, 32'h0,        0, 0, 0, 1, 0, 32'h08, 32'h4000_0008, 32'h2402_0002};
        vecs[5]  = '{1, 32'h2403_0003, 0, 0, 0, 0, 1, 32'h08, 32'h4000_0008, 32'h2403_0003};
        vecs[6]  = '{0, 32'h0,        0, 0, 0, 1, 0, 32'h0C, 32'h4000_000C, 32'h2403_0003};
        vecs[7]  = '{1, 32'h2404_0004, 1, 1, 0, 0, 1, 32'h0C, 32'h4000_000C, 32'h2404_0004};
        vecs[8]  = '{0, 32'h0,        0, 0, 0, 1, 0, 32'h10, 32'h4000_0010, 32'h2404_0004};
        vecs[9]  = '{1, 32'h1000_FFFE, 0, 0, 0, 0, 1, 32'h10, 32'h4000_0010, 32'h1000_FFFE};
        vecs[10] = '{0, 32'h0,        1, 0, 0, 1, 0, 32'h0C, 32'h4000_000C, 32'h1000_FFFE};
        vecs[11] = '{1, 32'h2405_0005, 0, 0, 0, 0, 1, 32'h0C, 32'h4000_000C, 32'h2405_0005};
        vecs[12] = '{0, 32'h0,        0, 0, 0, 1, 0, 32'h10, 32'h4000_0010, 32'h2405_0005};
        vecs[13] = '{1, 32'h1000_0003, 0, 0, 0, 0, 1, 32'h10, 32'h4000_0010, 32'h1000_0003};
        vecs[14] = '{0, 32'h0,        1, 0, 0, 1, 0, 32'h20, 32'h4000_0020, 32'h1000_0003};
        vecs[15] = '{1, 32'h0800_0010, 0, 0, 0, 0, 1, 32'h20, 32'h4000_0020, 32'h0800_0010};
        vecs[16] = '{0, 32'h0,        1, 1, 0, 1, 0, 32'h40, 32'h4000_0040, 32'h0800_0010};

        // Reset state
        reset = 1'b1;
        drive(0, 32'h0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_model();
        reset = 1'b0;
        $display("reset released: req=%b valid=%b pc=%h instr=%h", req_a, val_a, pc_a, instr_a);

        // Table-driven directed sequence
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].br, vecs[i].jp, vecs[i].hd);
            tick();
            chk($sformatf("vec%0d_req", i),   {31'b0, req_a}, {31'b0, vecs[i].e_req});
            chk($sformatf("vec%0d_valid", i), {31'b0, val_a}, {31'b0, vecs[i].e_val});
            chk($sformatf("vec%0d_addr_a", i), addr_a, vecs[i].e_addr_a);
            chk($sformatf("vec%0d_addr_b", i), addr_b, vecs[i].e_addr_b);
            chk($sformatf("vec%0d_instr", i), instr_a, vecs[i].e_instr);
            $display("vec %0d: req=%b valid=%b addr_a=%h addr_b=%h instr=%h",
                     i, req_a, val_a, addr_a, addr_b, instr_a);
        end

        // Hold extends the commit cycle: 1 + 3 held cycles of instr_valid
        drive(1, 32'h2406_0006, 0, 0, 0);
        tick();
        vcnt = val_a ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'hDEAD_BEEF, 0, 0, 1);
            tick();
            if (val_a) vcnt++;
            chk("hold_pc",    pc_a,    32'h40);
            chk("hold_instr", instr_a, 32'h2406_0006);
            $display("hold cycle %0d: valid=%b pc=%h instr=%h", i, val_a, pc_a, instr_a);
        end
        drive(0, 32'h0, 0, 0, 0);
        tick();
        chk("hold_valid_count", vcnt, 4);
        chk("hold_release_addr", addr_a, 32'h44);

        // Memory wait: address stable, no commit
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h0, 0, 0, 0);
            tick();
            chk("wait_addr",  addr_a, 32'h44);
            chk("wait_valid", {31'b0, val_a}, 32'h0);
            $display("wait cycle %0d: req=%b addr=%h valid=%b", i, req_a, addr_a, val_a);
        end
        drive(1, 32'h0800_0009, 0, 0, 0);
        tick();
        drive(0, 32'h0, 0, 1, 0);
        tick();
        chk("jump_to_24", addr_a, 32'h24);

        // Asynchronous reset mid-fetch
        #2 reset = 1'b1;
        #1;
        model_reset();
        cmp_model();
        $display("async reset: req=%b valid=%b pc=%h instr=%h", req_a, val_a, pc_a, instr_a);
        @(posedge clk);
        @(negedge clk);
        cmp_model();
        reset = 1'b0;
        chk("restart_idle_req", {31'b0, req_a}, 32'h0);
        tick();
        chk("restart_req",  {31'b0, req_a}, 32'h1);
        chk("restart_addr", addr_a, 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 55), $urandom(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 30);
            tick();
            if (val_a && !hold)
                $display("rand commit: pc_a=%h pc_b=%h instr=%h br=%b jp=%b",
                         pc_a, pc_b, instr_a, dobranch, dojump);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle MIPS core. Owns the program counter and requests instruction words from an instruction memory with a req/ack handshake. Presents a stable instruction word to the decoder for exactly one commit cycle. Consumes the decoder's `dobranch`/`dojump` to compute the next PC.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset; word-aligned.

Ports:
- `clk`  in  1  Core clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `imem_req`  out  1  Instruction fetch request.
- `imem_addr`  out  32  Fetch address; equals `pc`.
- `imem_ack`  in  1  Memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  Instruction word.
- `instr`  out  32  Registered instruction to the decoder.
- `instr_valid`  out  1  Commit cycle: the datapath may write registers and memory.
- `pc`  out  32  Address of `instr`.
- `pcplus4`  out  32  `pc + 4`, for the datapath.
- `dobranch`  in  1  From the decoder: take the relative branch.
- `dojump`  in  1  From the decoder: take the absolute jump.
- `hold`  in  1  External stall, e.g. from a slow data memory; extends the commit cycle.

## Operation

- States: IDLE, FETCH, EXEC. The state type and encoding live in the package.
- IDLE: entered on reset. Moves to FETCH unconditionally after one clock.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until ack.
  - On `imem_ack`: `instr` <= `imem_rdata`, then go to EXEC.
  - Without ack: remain in FETCH indefinitely.
- EXEC:
  - `instr_valid`=1, `imem_req`=0.
  - If `hold`=1: remain in EXEC. `instr` and `pc` are unchanged and `instr_valid` stays 1.
  - If `hold`=0: `pc` <= next PC, then go to FETCH.
- Next PC, priority order:
  1. `dojump`: {pcplus4[31:28], instr[25:0], 2'b00}
  2. `dobranch`: pcplus4 + (sign-extended instr[15:0] << 2)
  3. otherwise: pcplus4
- All PC arithmetic is 32-bit modulo 2^32; wrap-around is silent. Bits [1:0] are always 0.
- `dojump` and `dobranch` both high: the jump wins. They are sampled only in EXEC; in other states they are ignored, including X values.
- `imem_ack` is ignored outside FETCH.

## Timing

- Reset values:
  - state=IDLE, `pc`=RESET_PC, `pcplus4`=RESET_PC+4.
  - `instr`=32'h0000_0000 (NOP).
  - `instr_valid`=0, `imem_req`=0.
- Reset asserted mid-fetch or mid-EXEC:
  - All of the above apply immediately, without waiting for a clock edge.
  - A pending request is abandoned; the memory must tolerate a dropped `imem_req`.
- `imem_req`, `instr_valid` and `imem_addr` are decoded from registered state only; there are no combinational paths from inputs to them.
- Latency with zero-wait memory (ack in the first FETCH cycle): 2 cycles per instruction, 1 FETCH + 1 EXEC.
- First fetch request appears in the 2nd cycle after reset deassertion.
- `pc` changes only on the EXEC→FETCH edge.

## Structure

- Package `fetch_pkg`:
  - `fetch_state_t` enum {IDLE, FETCH, EXEC}.
  - `NOP_INSTR` constant.
  - Default `RESET_PC` constant.
- Sub-module `pc_next_logic` (combinational): inputs `pc`, `instr`, `dobranch`, `dojump`; outputs `pcplus4` and next PC. It is reused by the later pipelined core.
- The top level holds the state register, PC register and instruction register.

## Test plan

- **Reset:** assert `reset` with RESET_PC=0 -> `pc`=0, `instr`=0, `imem_req`=0, `instr_valid`=0. First `imem_req` with `imem_addr`=0 appears 2 cycles after deassert.
- **Sequential, zero-wait:** ack every request, feed `addiu` words, no branch/jump -> `imem_addr` sequence 0, 4, 8, 12; `instr_valid` high every other cycle.
- **Branch:** at `pc`=0x10 drive `dobranch`=1 with instr[15:0]=16'hFFFE -> next `imem_addr`=0x0C. With instr[15:0]=16'h0003 -> next `imem_addr`=0x20.
- **Jump and priority:** at `pc`=0x4000_0000, instr[25:0]=26'h10, `dojump`=`dobranch`=1 -> next `imem_addr`=0x4000_0040.
- **Hold and memory wait:**
  - `hold` for 3 EXEC cycles -> `instr_valid` high for 4 cycles; `pc` and `instr` unchanged.
  - Delay `imem_ack` 5 cycles -> `imem_addr` stable throughout and `instr_valid`=0.
- **Reset mid-fetch:** assert `reset` while in FETCH at `pc`=0x24 -> outputs return to reset values asynchronously, and fetching restarts at RESET_PC.
